// File: rtl/exp_host_pkg.sv
// Shared types for the CORDIC exponential host sequencer.
// Holds the sequencer state encoding and the bit positions inside the OVF/UNF flag vectors.
package exp_host_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      WAIT_ACK,
      HOLD
   } state_t;

   localparam int FX    = 0;
   localparam int FY    = 1;
   localparam int FZ    = 2;
   localparam int FMULT = 3;

endpackage

// File: rtl/exp_watchdog.sv
// Saturating watchdog counter used to abort an operation when the coprocessor never acknowledges.
// It flags expiry on the last allowed cycle, which is TIMEOUT-1.
module exp_watchdog #(
   parameter int unsigned TW      = 11,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TW-1:0] count;

   // clr wins over en; the counter holds at all-ones so it can never wrap back to zero
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en && (count != {TW{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/exp_host_sequencer.sv
// Host-side initiator for the CORDIC exponential coprocessor.
// Runs one operation at a time: accept argument, reset coprocessor, start, wait for ACK or timeout, hand result downstream.
module exp_host_sequencer
   import exp_host_pkg::*;
#(
   parameter int unsigned P       = 32,
   parameter int unsigned CLR_CYC = 2,
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned TW      = 11
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic [P-1:0] ARG_IN,
   input  logic         ARG_VALID,
   output logic         ARG_READY,
   output logic [P-1:0] T_OUT,
   output logic         RST_EX_OUT,
   output logic         BEGIN_FSM_EX,
   input  logic         ACK_EX,
   input  logic [P-1:0] RESULT_IN,
   input  logic [3:0]   OVF_IN,
   input  logic [3:0]   UNF_IN,
   output logic [P-1:0] RES_OUT,
   output logic [3:0]   RES_OVF,
   output logic [3:0]   RES_UNF,
   output logic         RES_TIMEOUT,
   output logic         RES_VALID,
   input  logic         RES_READY,
   output logic         BUSY
);

   state_t     state;
   state_t     next_state;
   logic [3:0] clr_cnt;
   logic       accept;
   logic       wd_expired;

   assign accept = (state == IDLE) && ARG_VALID;

   exp_watchdog #(
      .TW      (TW),
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (CLK),
      .rst     (RST),
      .clr     (accept),
      .en      (state == WAIT_ACK),
      .expired (wd_expired)
   );

   // ACK_EX is only looked at in WAIT_ACK, and it takes priority over watchdog expiry
   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (ARG_VALID) next_state = CLEAR;
         CLEAR:    if (clr_cnt == 4'(CLR_CYC - 1)) next_state = WAIT_ACK;
         WAIT_ACK: if (ACK_EX || wd_expired) next_state = HOLD;
         HOLD:     if (RES_READY) next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= IDLE;
         clr_cnt      <= '0;
         T_OUT        <= '0;
         BEGIN_FSM_EX <= 1'b0;
         RES_OUT      <= '0;
         RES_OVF      <= '0;
         RES_UNF      <= '0;
         RES_TIMEOUT  <= 1'b0;
         RES_VALID    <= 1'b0;
         BUSY         <= 1'b0;
      end else begin
         state        <= next_state;
         clr_cnt      <= (state == CLEAR) ? clr_cnt + 4'd1 : 4'd0;
         BEGIN_FSM_EX <= (next_state == WAIT_ACK);
         RES_VALID    <= (next_state == HOLD);
         BUSY         <= (next_state != IDLE);

         // Flags start clean at accept and only collect while the coprocessor is running
         case (state)
            IDLE: begin
               if (ARG_VALID) begin
                  T_OUT       <= ARG_IN;
                  RES_OVF     <= '0;
                  RES_UNF     <= '0;
                  RES_TIMEOUT <= 1'b0;
               end
            end
            WAIT_ACK: begin
               RES_OVF <= RES_OVF | OVF_IN;
               RES_UNF <= RES_UNF | UNF_IN;
               if (ACK_EX) begin
                  RES_OUT <= RESULT_IN;
               end else if (wd_expired) begin
                  RES_OUT     <= '0;
                  RES_TIMEOUT <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // The coprocessor is held in reset whenever the host is in reset, not only during CLEAR
   assign ARG_READY  = (state == IDLE) && !RST;
   assign RST_EX_OUT = RST || (state == CLEAR);

endmodule

// File: tb/tb_exp_host_sequencer.sv
// Directed self-checking bench for exp_host_sequencer with a result scoreboard.
// Expected results are queued when the coprocessor response is driven and popped when RES_VALID appears.
module tb_exp_host_sequencer;

   localparam int P       = 32;
   localparam int CLR_CYC = 2;
   localparam int TIMEOUT = 16;
   localparam int TW      = 5;

   logic         CLK;
   logic         RST;
   logic [P-1:0] ARG_IN;
   logic         ARG_VALID;
   logic         ARG_READY;
   logic [P-1:0] T_OUT;
   logic         RST_EX_OUT;
   logic         BEGIN_FSM_EX;
   logic         ACK_EX;
   logic [P-1:0] RESULT_IN;
   logic [3:0]   OVF_IN;
   logic [3:0]   UNF_IN;
   logic [P-1:0] RES_OUT;
   logic [3:0]   RES_OVF;
   logic [3:0]   RES_UNF;
   logic         RES_TIMEOUT;
   logic         RES_VALID;
   logic         RES_READY;
   logic         BUSY;

   typedef struct packed {
      logic [P-1:0] res;
      logic [3:0]   ovf;
      logic [3:0]   unf;
      logic         tmo;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   exp_host_sequencer #(
      .P       (P),
      .CLR_CYC (CLR_CYC),
      .TIMEOUT (TIMEOUT),
      .TW      (TW)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .ARG_IN       (ARG_IN),
      .ARG_VALID    (ARG_VALID),
      .ARG_READY    (ARG_READY),
      .T_OUT        (T_OUT),
      .RST_EX_OUT   (RST_EX_OUT),
      .BEGIN_FSM_EX (BEGIN_FSM_EX),
      .ACK_EX       (ACK_EX),
      .RESULT_IN    (RESULT_IN),
      .OVF_IN       (OVF_IN),
      .UNF_IN       (UNF_IN),
      .RES_OUT      (RES_OUT),
      .RES_OVF      (RES_OVF),
      .RES_UNF      (RES_UNF),
      .RES_TIMEOUT  (RES_TIMEOUT),
      .RES_VALID    (RES_VALID),
      .RES_READY    (RES_READY),
      .BUSY         (BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] global time limit reached");
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pushExpected(input logic [P-1:0] res, input logic [3:0] ovf, input logic [3:0] unf, input logic tmo);
      exp_t e;
      e.res = res;
      e.ovf = ovf;
      e.unf = unf;
      e.tmo = tmo;
      sb.push_back(e);
   endtask

   task automatic applyStimulus(input logic [P-1:0] arg);
      int n = 0;
      ARG_IN    = arg;
      ARG_VALID = 1'b1;
      while (!ARG_READY && n < 50) begin
         step();
         n++;
      end
      checkOutput("accept_ready", 32'(ARG_READY), 32'd1);
      step();
      ARG_VALID = 1'b0;
   endtask

   task automatic waitBegin();
      int n = 0;
      while (!BEGIN_FSM_EX && n < 50) begin
         step();
         n++;
      end
      checkOutput("begin_rise", 32'(BEGIN_FSM_EX), 32'd1);
   endtask

   task automatic collectResult(input string tag);
      int   n = 0;
      exp_t e;
      while (!RES_VALID && n < 50) begin
         step();
         n++;
      end
      checkOutput({tag, "_valid"}, 32'(RES_VALID), 32'd1);
      checks++;
      assert (sb.size() > 0) else begin
         errors++;
         $error("[TB] FAIL %s_sb: observed empty scoreboard expected a queued result", tag);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput({tag, "_res"}, RES_OUT, e.res);
         checkOutput({tag, "_ovf"}, 32'(RES_OVF), 32'(e.ovf));
         checkOutput({tag, "_unf"}, 32'(RES_UNF), 32'(e.unf));
         checkOutput({tag, "_tmo"}, 32'(RES_TIMEOUT), 32'(e.tmo));
      end
   endtask

   initial begin
      int n;

      RST       = 1'b1;
      ARG_IN    = '0;
      ARG_VALID = 1'b0;
      ACK_EX    = 1'b0;
      RESULT_IN = '0;
      OVF_IN    = '0;
      UNF_IN    = '0;
      RES_READY = 1'b1;
      repeat (3) step();

      // reset values
      checkOutput("rst_arg_ready", 32'(ARG_READY), 32'd0);
      checkOutput("rst_rst_ex", 32'(RST_EX_OUT), 32'd1);
      checkOutput("rst_begin", 32'(BEGIN_FSM_EX), 32'd0);
      checkOutput("rst_valid", 32'(RES_VALID), 32'd0);
      checkOutput("rst_busy", 32'(BUSY), 32'd0);
      checkOutput("rst_t_out", T_OUT, 32'd0);
      checkOutput("rst_res_out", RES_OUT, 32'd0);
      RST = 1'b0;
      step();
      checkOutput("post_rst_arg_ready", 32'(ARG_READY), 32'd1);
      checkOutput("post_rst_rst_ex", 32'(RST_EX_OUT), 32'd0);

      // basic op with exact cycle timing, accept at edge 0
      ARG_IN    = 32'h3F00_0000;
      ARG_VALID = 1'b1;
      step();
      ARG_VALID = 1'b0;
      checkOutput("c1_rst_ex", 32'(RST_EX_OUT), 32'd1);
      checkOutput("c1_begin", 32'(BEGIN_FSM_EX), 32'd0);
      checkOutput("c1_t_out", T_OUT, 32'h3F00_0000);
      checkOutput("c1_arg_ready", 32'(ARG_READY), 32'd0);
      checkOutput("c1_busy", 32'(BUSY), 32'd1);
      step();
      checkOutput("c2_rst_ex", 32'(RST_EX_OUT), 32'd1);
      checkOutput("c2_begin", 32'(BEGIN_FSM_EX), 32'd0);
      step();
      checkOutput("c3_rst_ex", 32'(RST_EX_OUT), 32'd0);
      checkOutput("c3_begin", 32'(BEGIN_FSM_EX), 32'd1);
      repeat (7) step();
      checkOutput("c10_valid", 32'(RES_VALID), 32'd0);
      ACK_EX    = 1'b1;
      RESULT_IN = 32'h3FD3_094C;
      pushExpected(32'h3FD3_094C, 4'b0000, 4'b0000, 1'b0);
      step();
      ACK_EX = 1'b0;
      checkOutput("c11_valid", 32'(RES_VALID), 32'd1);
      checkOutput("c11_begin", 32'(BEGIN_FSM_EX), 32'd0);
      collectResult("basic");
      step();
      checkOutput("c12_valid", 32'(RES_VALID), 32'd0);
      checkOutput("c12_arg_ready", 32'(ARG_READY), 32'd1);

      // flag accumulation, then a clean op must report zero flags
      applyStimulus(32'h0000_0001);
      waitBegin();
      OVF_IN = 4'b0001;
      step();
      OVF_IN = 4'b1000;
      UNF_IN = 4'b0100;
      step();
      OVF_IN    = 4'b0000;
      UNF_IN    = 4'b0000;
      ACK_EX    = 1'b1;
      RESULT_IN = 32'h4000_0000;
      pushExpected(32'h4000_0000, 4'b1001, 4'b0100, 1'b0);
      step();
      ACK_EX = 1'b0;
      collectResult("flags");
      step();
      applyStimulus(32'h0000_0002);
      waitBegin();
      step();
      ACK_EX    = 1'b1;
      RESULT_IN = 32'h0000_0005;
      pushExpected(32'h0000_0005, 4'b0000, 4'b0000, 1'b0);
      step();
      ACK_EX = 1'b0;
      collectResult("flags_clear");
      step();

      // backpressure in HOLD with flags and a pending argument that must not be taken
      applyStimulus(32'hA5A5_0001);
      waitBegin();
      OVF_IN = 4'b0010;
      step();
      OVF_IN    = 4'b0000;
      ACK_EX    = 1'b1;
      RESULT_IN = 32'h1234_5678;
      RES_READY = 1'b0;
      pushExpected(32'h1234_5678, 4'b0010, 4'b0000, 1'b0);
      step();
      ACK_EX    = 1'b0;
      RESULT_IN = 32'h0;
      OVF_IN    = 4'b0100;
      UNF_IN    = 4'b1111;
      ARG_IN    = 32'h0BAD_F00D;
      ARG_VALID = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_valid", 32'(RES_VALID), 32'd1);
         checkOutput("bp_res_out", RES_OUT, 32'h1234_5678);
         checkOutput("bp_ovf", 32'(RES_OVF), 32'h2);
         checkOutput("bp_unf", 32'(RES_UNF), 32'h0);
         checkOutput("bp_arg_ready", 32'(ARG_READY), 32'd0);
         checkOutput("bp_t_out", T_OUT, 32'hA5A5_0001);
         step();
      end
      OVF_IN = 4'b0000;
      UNF_IN = 4'b0000;
      collectResult("backpressure");
      RES_READY = 1'b1;
      step();
      checkOutput("bp_idle_valid", 32'(RES_VALID), 32'd0);
      checkOutput("bp_idle_ready", 32'(ARG_READY), 32'd1);
      checkOutput("bp_idle_t_out", T_OUT, 32'hA5A5_0001);
      step();
      ARG_VALID = 1'b0;
      checkOutput("bp_next_t_out", T_OUT, 32'h0BAD_F00D);
      checkOutput("bp_next_busy", 32'(BUSY), 32'd1);
      waitBegin();
      ACK_EX    = 1'b1;
      RESULT_IN = 32'h0BAD_F00E;
      pushExpected(32'h0BAD_F00E, 4'b0000, 4'b0000, 1'b0);
      step();
      ACK_EX = 1'b0;
      collectResult("after_bp");
      step();

      // watchdog expiry: result 16 cycles after BEGIN rises
      RESULT_IN = 32'hDEAD_BEEF;
      applyStimulus(32'h0000_0003);
      waitBegin();
      pushExpected(32'h0, 4'b0000, 4'b0000, 1'b1);
      n = 0;
      while (!RES_VALID && n < 40) begin
         step();
         n++;
      end
      checkOutput("timeout_latency", 32'(n), 32'd16);
      collectResult("timeout");
      step();

      // ACK on the expiry cycle wins over the watchdog
      applyStimulus(32'h0000_0004);
      waitBegin();
      repeat (TIMEOUT - 1) step();
      checkOutput("pre_expiry_valid", 32'(RES_VALID), 32'd0);
      ACK_EX    = 1'b1;
      RESULT_IN = 32'hCAFE_0001;
      pushExpected(32'hCAFE_0001, 4'b0000, 4'b0000, 1'b0);
      step();
      ACK_EX = 1'b0;
      collectResult("ack_at_expiry");
      step();

      // stale ACK in IDLE and CLEAR must be ignored
      ACK_EX    = 1'b1;
      RESULT_IN = 32'hBAD0_0BAD;
      step();
      checkOutput("stale_idle_valid", 32'(RES_VALID), 32'd0);
      checkOutput("stale_idle_busy", 32'(BUSY), 32'd0);
      applyStimulus(32'h0000_0005);
      waitBegin();
      ACK_EX = 1'b0;
      checkOutput("stale_busy", 32'(BUSY), 32'd1);
      checkOutput("stale_valid", 32'(RES_VALID), 32'd0);
      repeat (2) step();
      checkOutput("stale_still_waiting", 32'(RES_VALID), 32'd0);
      ACK_EX    = 1'b1;
      RESULT_IN = 32'h600D_0001;
      pushExpected(32'h600D_0001, 4'b0000, 4'b0000, 1'b0);
      step();
      ACK_EX = 1'b0;
      collectResult("stale_ack");
      step();

      // reset in the middle of WAIT_ACK aborts without a result
      applyStimulus(32'h0000_0006);
      waitBegin();
      repeat (2) step();
      RST = 1'b1;
      step();
      checkOutput("midrst_begin", 32'(BEGIN_FSM_EX), 32'd0);
      checkOutput("midrst_valid", 32'(RES_VALID), 32'd0);
      checkOutput("midrst_busy", 32'(BUSY), 32'd0);
      checkOutput("midrst_arg_ready", 32'(ARG_READY), 32'd0);
      checkOutput("midrst_rst_ex", 32'(RST_EX_OUT), 32'd1);
      RST = 1'b0;
      step();
      checkOutput("midrst_after_ready", 32'(ARG_READY), 32'd1);
      checkOutput("midrst_after_rst_ex", 32'(RST_EX_OUT), 32'd0);
      checkOutput("midrst_after_valid", 32'(RES_VALID), 32'd0);
      checkOutput("midrst_after_res_out", RES_OUT, 32'd0);
      checkOutput("midrst_after_t_out", T_OUT, 32'd0);
      checkOutput("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
